// File: rtl/fetch_buff_responder.sv
// Fetch-side instruction buffer responder: queues fetch read strobes in order and
// serves them one at a time from instruction memory, returning word plus tag.
`timescale 1ns/1ps

module fetch_buff_responder #(
   parameter int QDEPTH = 4,
   parameter int QPTR_W = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        buff_rd_en,
   input  logic [31:0] buff_addr,
   input  logic [38:0] buff_tag,
   input  logic        buff_flush,
   output logic        buff_ready,
   output logic        buff_ack,
   output logic [31:0] buff_instr,
   output logic [38:0] buff_tag_out,
   output logic        buff_overflow,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rd_data
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP,
      ST_DRAIN
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [31:0]       r_q_addr [QDEPTH];
   logic [38:0]       r_q_tag  [QDEPTH];
   logic [QPTR_W-1:0] r_wr_ptr;
   logic [QPTR_W-1:0] r_rd_ptr;
   logic [QPTR_W:0]   r_count;

   logic        w_push;
   logic        w_pop;
   logic        w_load_addr;
   logic        w_latch_resp;
   logic [31:0] w_head_addr;
   logic [38:0] w_head_tag;

   // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
   assign buff_ready  = (r_count < (QPTR_W+1)'(QDEPTH));
   assign w_push      = buff_rd_en & buff_ready & ~buff_flush;
   assign w_pop       = (r_state == ST_WAIT) & mem_ack & ~buff_flush;
   assign w_head_addr = r_q_addr[r_rd_ptr];
   assign w_head_tag  = r_q_tag[r_rd_ptr];

   assign mem_rd_en = (r_state == ST_REQ);
   assign buff_ack  = (r_state == ST_RESP);

   genvar gi;
   generate
      for (gi = 0; gi < QDEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (w_push && (r_wr_ptr == QPTR_W'(gi))) begin
               r_q_addr[gi] <= buff_addr;
               r_q_tag[gi]  <= buff_tag;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (buff_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // A strobe coinciding with flush is simply dropped and does not count as overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buff_overflow <= 1'b0;
      end else if (buff_rd_en && !buff_ready && !buff_flush) begin
         buff_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load_addr  = 1'b0;
      w_latch_resp = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!buff_flush && (r_count != '0)) begin
               w_state_next = ST_REQ;
               w_load_addr  = 1'b1;
            end
         end
         ST_REQ: begin
            w_state_next = buff_flush ? ST_DRAIN : ST_WAIT;
         end
         ST_WAIT: begin
            // Flush together with the ack consumes that ack, so no drain is needed.
            if (mem_ack) begin
               w_state_next = buff_flush ? ST_IDLE : ST_RESP;
               w_latch_resp = ~buff_flush;
            end else if (buff_flush) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_RESP: begin
            if (!buff_flush && (r_count != '0)) begin
               w_state_next = ST_REQ;
               w_load_addr  = 1'b1;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (mem_ack) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr     <= '0;
         buff_instr   <= '0;
         buff_tag_out <= '0;
      end else begin
         if (w_load_addr) begin
            mem_addr <= w_head_addr & 32'hFFFF_FFFC;
         end
         if (w_latch_resp) begin
            buff_instr   <= mem_rd_data;
            buff_tag_out <= w_head_tag;
         end
      end
   end

endmodule
